// File: rtl/misc_pipe_acc.sv
// misc_pipe_acc: three-stage pipelined mixed-width arithmetic unit.
// Stage 1 forms the A/B branch operands, stage 2 evaluates the selected
// operation, stage 3 is the output register with the optional accumulator.
// All stages advance together whenever the output register is free or
// being drained.
module misc_pipe_acc #(
    parameter int AW  = 8,
    parameter int BW  = 4,
    parameter int SAT = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [AW-1:0] C,
    input  logic [1:0]    MODE,
    input  logic          CLR_ACC,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [AW-1:0] XOUT,
    output logic          OVF
);

    localparam logic [1:0]    MODE_PROD = 2'd0;
    localparam logic [1:0]    MODE_SUM  = 2'd1;
    localparam logic [1:0]    MODE_OFS  = 2'd2;
    localparam logic [1:0]    MODE_ACC  = 2'd3;
    localparam logic [AW-1:0] OFS_BIAS  = AW'(3'd4);
    localparam logic [AW-1:0] ALL_ONES  = {AW{1'b1}};

    // Output register state (also drives the handshake)
    logic          r_out_valid;
    logic [AW-1:0] r_xout;
    logic          r_ovf;
    logic [AW-1:0] r_acc;

    // Stage 1 registers
    logic          r_v1;
    logic [1:0]    r_mode1;
    logic [AW-1:0] r_c1;
    logic [AW-1:0] r_na1;
    logic [AW-1:0] r_nb1;
    logic [AW-1:0] r_s0_1;
    logic [AW-1:0] r_s1_1;

    // Stage 2 registers
    logic          r_v2;
    logic          r_acc_op2;
    logic [AW-1:0] r_r2;
    logic          r_ovf2;

    // Handshake
    logic w_advance;
    logic w_accept;

    assign w_advance = ~r_out_valid | OUT_READY;
    assign IN_READY  = w_advance & ~RESET;
    assign w_accept  = IN_VALID & IN_READY;

    assign OUT_VALID = r_out_valid;
    assign XOUT      = r_xout;
    assign OVF       = r_ovf;

    // ---------------- Stage 1 combinational ----------------
    logic [AW-1:0] w_bx;
    logic [AW-1:0] w_na;
    logic [AW-1:0] w_nb;
    logic [AW-1:0] w_s0;
    logic [AW-1:0] w_s1;

    assign w_bx = AW'(B);
    assign w_na = A - w_bx;
    assign w_nb = A + w_bx;

    // Branch selection: the larger-A branch multiplies A by (A+B)
    always_comb begin
        w_s0 = w_na;
        w_s1 = w_nb;
        if (A > w_bx) begin
            w_s0 = w_nb;
            w_s1 = A;
        end else begin
            w_s0 = w_na;
            w_s1 = w_nb;
        end
    end

    // Stage 1 register: captures the accepted sample's derived operands
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_v1    <= 1'b0;
            r_mode1 <= 2'b00;
            r_c1    <= {AW{1'b0}};
            r_na1   <= {AW{1'b0}};
            r_nb1   <= {AW{1'b0}};
            r_s0_1  <= {AW{1'b0}};
            r_s1_1  <= {AW{1'b0}};
        end else if (w_advance) begin
            r_v1    <= w_accept;
            r_mode1 <= MODE;
            r_c1    <= C;
            r_na1   <= w_na;
            r_nb1   <= w_nb;
            r_s0_1  <= w_s0;
            r_s1_1  <= w_s1;
        end else begin
            r_v1    <= r_v1;
        end
    end

    // ---------------- Stage 2 combinational ----------------
    logic [2*AW-1:0] w_pf;
    logic [AW-1:0]   w_p;
    logic            w_pt;
    logic [AW:0]     w_nsum;
    logic [AW-1:0]   w_ofs;
    logic [AW-1:0]   w_r;
    logic            w_ovf;

    assign w_pf   = {{AW{1'b0}}, r_s0_1} * {{AW{1'b0}}, r_s1_1};
    assign w_p    = w_pf[AW-1:0];
    assign w_pt   = |w_pf[2*AW-1:AW];
    assign w_nsum = {1'b0, r_na1} + {1'b0, r_nb1};
    assign w_ofs  = r_na1 + r_c1 + OFS_BIAS;

    // Operation select; accumulate mode carries the product to stage 3
    always_comb begin
        w_r   = w_p;
        w_ovf = w_pt;
        case (r_mode1)
            MODE_PROD: begin
                w_r   = w_p;
                w_ovf = w_pt;
            end
            MODE_SUM: begin
                w_r   = w_nsum[AW-1:0];
                w_ovf = w_nsum[AW];
            end
            MODE_OFS: begin
                w_r   = w_ofs;
                w_ovf = 1'b0;
            end
            MODE_ACC: begin
                w_r   = w_p;
                w_ovf = w_pt;
            end
            default: begin
                w_r   = w_p;
                w_ovf = w_pt;
            end
        endcase
    end

    // Stage 2 register: holds the per-sample result and flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_v2      <= 1'b0;
            r_acc_op2 <= 1'b0;
            r_r2      <= {AW{1'b0}};
            r_ovf2    <= 1'b0;
        end else if (w_advance) begin
            r_v2      <= r_v1;
            r_acc_op2 <= (r_mode1 == MODE_ACC);
            r_r2      <= w_r;
            r_ovf2    <= w_ovf;
        end else begin
            r_v2      <= r_v2;
        end
    end

    // ---------------- Stage 3 accumulator ----------------
    logic [AW-1:0] w_acc_base;
    logic [AW:0]   w_acc_sum;
    logic [AW-1:0] w_acc_new;
    logic          w_load;
    logic          w_acc_load;

    // A clear coinciding with an accumulate load restarts from zero
    assign w_acc_base = CLR_ACC ? {AW{1'b0}} : r_acc;
    assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, r_r2};
    assign w_load     = w_advance & r_v2;
    assign w_acc_load = w_load & r_acc_op2;

    // Accumulator overflow handling: clamp or wrap
    always_comb begin
        w_acc_new = w_acc_sum[AW-1:0];
        if (w_acc_sum[AW] && (SAT != 0)) begin
            w_acc_new = ALL_ONES;
        end else begin
            w_acc_new = w_acc_sum[AW-1:0];
        end
    end

    // Accumulator register; a standalone clear works even while stalled
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc <= {AW{1'b0}};
        end else if (w_acc_load) begin
            r_acc <= w_acc_new;
        end else if (CLR_ACC) begin
            r_acc <= {AW{1'b0}};
        end else begin
            r_acc <= r_acc;
        end
    end

    // Output register: loads on advance, a bubble only drops OUT_VALID
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_xout      <= {AW{1'b0}};
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                if (r_acc_op2) begin
                    r_xout <= w_acc_new;
                    r_ovf  <= r_ovf2 | w_acc_sum[AW];
                end else begin
                    r_xout <= r_r2;
                    r_ovf  <= r_ovf2;
                end
            end else begin
                r_xout <= r_xout;
                r_ovf  <= r_ovf;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

endmodule

// File: tb/tb_misc_pipe_acc.sv
// Bench for misc_pipe_acc: a wrapping (SAT=0) and a clamping (SAT=1) instance
// share one stimulus; a behavioural model predicts both every cycle, and
// directed sequences pin hand-computed results.
module tb_misc_pipe_acc;

    logic       CLK = 1'b0;
    logic       RESET, IN_VALID, OUT_READY, CLR_ACC;
    logic [7:0] A, C;
    logic [3:0] B;
    logic [1:0] MODE;

    logic       in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [7:0] xout0, xout1;

    always #5 CLK = ~CLK;

    misc_pipe_acc #(.AW(8), .BW(4), .SAT(0)) u_wrap (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready0),
        .A(A), .B(B), .C(C), .MODE(MODE), .CLR_ACC(CLR_ACC),
        .OUT_VALID(out_valid0), .OUT_READY(OUT_READY), .XOUT(xout0), .OVF(ovf0)
    );

    misc_pipe_acc #(.AW(8), .BW(4), .SAT(1)) u_sat (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready1),
        .A(A), .B(B), .C(C), .MODE(MODE), .CLR_ACC(CLR_ACC),
        .OUT_VALID(out_valid1), .OUT_READY(OUT_READY), .XOUT(xout1), .OVF(ovf1)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit v; int a; int b; int c; int mode; } smp_t;
    typedef struct { int x0; int o0; int x1; int o1; } res_t;

    smp_t m_s1, m_s2;
    bit   m_out_valid = 1'b0;
    int   m_xout[2];
    int   m_ovf[2];
    int   m_acc[2];
    res_t log_q[$];

    function automatic void calc(input smp_t s, output int r, output int o, output int p, output int pt);
        int na, nb, s0, s1, pf, t;
        na = (s.a - s.b + 256) % 256;
        nb = (s.a + s.b) % 256;
        if (s.a > s.b) begin s0 = nb; s1 = s.a; end
        else begin s0 = na; s1 = nb; end
        pf = s0 * s1;
        p  = pf % 256;
        pt = (pf >= 256) ? 1 : 0;
        case (s.mode)
            1: begin t = na + nb; r = t % 256; o = (t >= 256) ? 1 : 0; end
            2: begin r = (na + s.c + 4) % 256; o = 0; end
            default: begin r = p; o = pt; end
        endcase
    endfunction

    task automatic model_step();
        int r, o, p, pt, sum;
        if (RESET) begin
            m_s1.v = 1'b0; m_s2.v = 1'b0; m_out_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin m_xout[k] = 0; m_ovf[k] = 0; m_acc[k] = 0; end
        end else if (!m_out_valid || OUT_READY) begin
            if (m_s2.v) begin
                calc(m_s2, r, o, p, pt);
                for (int k = 0; k < 2; k++) begin
                    if (m_s2.mode == 3) begin
                        sum = (CLR_ACC ? 0 : m_acc[k]) + p;
                        if (sum >= 256) m_acc[k] = (k == 1) ? 255 : sum - 256;
                        else m_acc[k] = sum;
                        m_xout[k] = m_acc[k];
                        m_ovf[k]  = (pt != 0 || sum >= 256) ? 1 : 0;
                    end else begin
                        m_xout[k] = r;
                        m_ovf[k]  = o;
                        if (CLR_ACC) m_acc[k] = 0;
                    end
                end
                m_out_valid = 1'b1;
            end else begin
                m_out_valid = 1'b0;
                if (CLR_ACC) begin m_acc[0] = 0; m_acc[1] = 0; end
            end
            m_s2      = m_s1;
            m_s1.v    = IN_VALID;
            m_s1.a    = int'(A);
            m_s1.b    = int'(B);
            m_s1.c    = int'(C);
            m_s1.mode = int'(MODE);
        end else if (CLR_ACC) begin
            m_acc[0] = 0; m_acc[1] = 0;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // compare process and result log, sampled on the falling edge
    initial forever begin
        int exp_ir;
        res_t e;
        @(negedge CLK);
        if (chk_en) begin
            exp_ir = ((!m_out_valid || OUT_READY) && !RESET) ? 1 : 0;
            chk("out_valid_wrap", int'(out_valid0), int'(m_out_valid));
            chk("out_valid_sat",  int'(out_valid1), int'(m_out_valid));
            chk("in_ready_wrap",  int'(in_ready0),  exp_ir);
            chk("in_ready_sat",   int'(in_ready1),  exp_ir);
            chk("xout_wrap", int'(xout0), m_xout[0]);
            chk("ovf_wrap",  int'(ovf0),  m_ovf[0]);
            chk("xout_sat",  int'(xout1), m_xout[1]);
            chk("ovf_sat",   int'(ovf1),  m_ovf[1]);
        end
        if (out_valid0 && OUT_READY) begin
            e.x0 = int'(xout0); e.o0 = int'(ovf0); e.x1 = int'(xout1); e.o1 = int'(ovf1);
            log_q.push_back(e);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic drive(input bit v, input int a, input int b, input int c, input int mode, input bit clr);
        IN_VALID = v; A = 8'(a); B = 4'(b); C = 8'(c); MODE = 2'(mode); CLR_ACC = clr;
    endtask

    task automatic idle();
        IN_VALID = 1'b0; CLR_ACC = 1'b0;
    endtask

    task automatic expect_res(input string name, input int idx, input int x0, input int o0, input int x1, input int o1);
        if (log_q.size() > idx) begin
            chk({name, "_xout_wrap"}, log_q[idx].x0, x0);
            chk({name, "_ovf_wrap"},  log_q[idx].o0, o0);
            chk({name, "_xout_sat"},  log_q[idx].x1, x1);
            chk({name, "_ovf_sat"},   log_q[idx].o1, o1);
        end else begin
            chk({name, "_present"}, log_q.size(), idx + 1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int k;
        RESET = 1'b1; OUT_READY = 1'b1;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        cyc(2);
        chk_en = 1'b1;

        // reset state, literal
        @(negedge CLK);
        chk("reset_out_valid", int'(out_valid0), 0);
        chk("reset_xout",      int'(xout0), 0);
        chk("reset_ovf",       int'(ovf0), 0);
        chk("reset_in_ready",  int'(in_ready0), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        cyc(1);

        // MODE0 with latency measurement
        log_q.delete();
        drive(1'b1, 20, 3, 0, 0, 1'b0);
        cyc(1);
        idle();
        lat = 1;
        while (lat < 10) begin
            @(negedge CLK);
            if (out_valid0) break;
            @(posedge CLK);
            lat++;
        end
        @(posedge CLK); #1;
        chk("latency", lat, 3);
        cyc(3);
        expect_res("mode0", 0, 204, 1, 204, 1);

        // MODE1 and MODE2 back to back
        log_q.delete();
        drive(1'b1, 2, 5, 0, 1, 1'b0);    cyc(1);
        drive(1'b1, 10, 1, 8'h30, 2, 1'b0); cyc(1);
        idle(); cyc(5);
        expect_res("mode1", 0, 4, 1, 4, 1);
        expect_res("mode2", 1, 61, 0, 61, 0);

        // MODE3 accumulate, three back-to-back samples
        CLR_ACC = 1'b1; cyc(1); CLR_ACC = 1'b0;
        log_q.delete();
        drive(1'b1, 4, 0, 0, 3, 1'b0); cyc(3);
        idle(); cyc(5);
        expect_res("acc1", 0, 16, 0, 16, 0);
        expect_res("acc2", 1, 32, 0, 32, 0);
        expect_res("acc3", 2, 48, 0, 48, 0);

        // clear coinciding with an accumulate load (acc = 48)
        log_q.delete();
        drive(1'b1, 4, 0, 0, 3, 1'b0); cyc(1);
        idle(); cyc(1);
        CLR_ACC = 1'b1; cyc(1); CLR_ACC = 1'b0;
        cyc(3);
        chk("clr_load_count", log_q.size(), 1);
        expect_res("clr_load", 0, 16, 0, 16, 0);

        // saturate versus wrap
        CLR_ACC = 1'b1; cyc(1); CLR_ACC = 1'b0;
        log_q.delete();
        drive(1'b1, 15, 1, 0, 3, 1'b0); cyc(2);
        idle(); cyc(5);
        expect_res("sat1", 0, 240, 0, 240, 0);
        expect_res("sat2", 1, 224, 1, 255, 1);

        // stall: OUT_READY low for 6 cycles, distinct samples offered
        log_q.delete();
        OUT_READY = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, k + 1, 0, 0, 0, 1'b0);
            @(negedge CLK);
            if (IN_VALID && in_ready0) k++;
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("stall_accepts", k, 3);
        chk("stall_out_valid", int'(out_valid0), 1);
        chk("stall_in_ready", int'(in_ready0), 0);
        @(posedge CLK); #1;
        idle(); OUT_READY = 1'b1;
        cyc(6);
        chk("stall_count", log_q.size(), 3);
        expect_res("stall0", 0, 1, 0, 1, 0);
        expect_res("stall1", 1, 4, 0, 4, 0);
        expect_res("stall2", 2, 9, 0, 9, 0);

        // reset with two samples in flight
        drive(1'b1, 4, 0, 0, 3, 1'b0); cyc(1);
        idle(); cyc(4);
        log_q.delete();
        drive(1'b1, 20, 3, 0, 0, 1'b0); cyc(1);
        drive(1'b1, 2, 5, 0, 1, 1'b0);  cyc(1);
        idle(); RESET = 1'b1; cyc(1);
        @(negedge CLK);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_xout", int'(xout0), 0);
        chk("rst_ovf", int'(ovf0), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        cyc(5);
        chk("rst_dropped", log_q.size(), 0);
        drive(1'b1, 4, 0, 0, 3, 1'b0); cyc(1);
        idle(); cyc(4);
        expect_res("rst_acc", 0, 16, 0, 16, 0);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            RESET     = ($urandom_range(0, 99) == 0);
            OUT_READY = ($urandom_range(0, 9) < 7);
            CLR_ACC   = ($urandom_range(0, 19) == 0);
            IN_VALID  = ($urandom_range(0, 3) != 0);
            A         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            B         = 4'($urandom_range(0, 15));
            C         = 8'($urandom_range(0, 255));
            MODE      = 2'($urandom_range(0, 3));
            cyc(1);
        end
        RESET = 1'b0; OUT_READY = 1'b1; idle();
        cyc(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
